// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Ceiling log2 with a floor of 1, so a width derived from it is never zero.
    function automatic int clogb2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Next round-robin start index; wraps at the producer count, not at a power of two.
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating priority encoder: finds the first set request searching upward
// from start_ptr_i, wrapping at N_SRC. Purely combinational.
module rr_prio_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = clogb2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [SRC_W-1:0] start_ptr_i,
    output logic             any_o,
    output logic [SRC_W-1:0] idx_o
);

    logic [SRC_W-1:0] cand;

    // Scan from the farthest candidate back to the start so the nearest hit wins.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        cand  = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            cand = SRC_W'((int'(start_ptr_i) + i) % N_SRC);
            if (req_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N_SRC producers.
// Optional feature macro: FIFO_ARB_TAG_EN prepends the granted source id to
// every beat written into the FIFO.
module fifo_rr_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4,
    parameter int SRC_W     = clogb2(N_SRC),
`ifdef FIFO_ARB_TAG_EN
    parameter int FIFO_DW   = DATA_W + SRC_W
`else
    parameter int FIFO_DW   = DATA_W
`endif
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [N_SRC-1:0]             s_valid_i,
    input  logic [N_SRC-1:0][DATA_W-1:0] s_data_i,
    input  logic [N_SRC-1:0]             s_last_i,
    output logic [N_SRC-1:0]             s_ready_o,
    output logic                         fifo_w_req_o,
    output logic [FIFO_DW-1:0]           fifo_w_data_o,
    input  logic                         fifo_full_i,
    output logic                         grant_valid_o,
    output logic [SRC_W-1:0]             grant_id_o
);

    localparam int CNT_W = clogb2(BURST_MAX) + 1;

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0] grant_id_q, grant_id_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             pick_any;
    logic [SRC_W-1:0] pick_idx;
    logic             grant_ready;
    logic             xfer;
    logic             release_grant;

    rr_prio_pick #(
        .N_SRC (N_SRC),
        .SRC_W (SRC_W)
    ) u_pick (
        .req_i       (s_valid_i),
        .start_ptr_i (rr_ptr_q),
        .any_o       (pick_any),
        .idx_o       (pick_idx)
    );

    // Next-state and output decode; the reset term keeps any write out of a reset cycle.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        beat_cnt_d    = beat_cnt_q;
        s_ready_o     = '0;
        fifo_w_req_o  = 1'b0;
        fifo_w_data_o = '0;
        grant_ready   = 1'b0;
        xfer          = 1'b0;
        release_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d    = GRANT;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            GRANT: begin
                grant_ready           = ~fifo_full_i & nrst;
                s_ready_o[grant_id_q] = grant_ready;
                xfer                  = s_valid_i[grant_id_q] & grant_ready;
                fifo_w_req_o          = xfer;
                if (xfer) begin
`ifdef FIFO_ARB_TAG_EN
                    fifo_w_data_o = {grant_id_q, s_data_i[grant_id_q]};
`else
                    fifo_w_data_o = s_data_i[grant_id_q];
`endif
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                release_grant = (xfer & s_last_i[grant_id_q])
                              | (xfer & (beat_cnt_q == CNT_W'(BURST_MAX - 1)))
                              | ~s_valid_i[grant_id_q];
                if (release_grant) begin
                    state_d  = IDLE;
                    rr_ptr_d = SRC_W'(rr_next(int'(grant_id_q), N_SRC));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_valid_o = (state_q == GRANT);
    assign grant_id_o    = grant_id_q;

endmodule

// File: tb/tb_fifo_rr_write_arbiter.sv
// Scoreboard testbench for fifo_rr_write_arbiter (4-source main instance plus a
// 3-source instance for the non-power-of-two wrap).
module tb_fifo_rr_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int BM = 4;
    localparam int SW = 2;
`ifdef FIFO_ARB_TAG_EN
    localparam int FDW  = DW + SW;
    localparam int FDW3 = DW + 2;
`else
    localparam int FDW  = DW;
    localparam int FDW3 = DW;
`endif

    typedef struct {
        int            src;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                  clk;
    logic                  nrst;
    logic [N-1:0]          sValid;
    logic [N-1:0][DW-1:0]  sData;
    logic [N-1:0]          sLast;
    logic [N-1:0]          sReady;
    logic                  wReq;
    logic [FDW-1:0]        wData;
    logic                  fifoFull;
    logic                  grantValid;
    logic [SW-1:0]         grantId;

    logic [2:0]            s3Valid;
    logic [2:0][DW-1:0]    s3Data;
    logic [2:0]            s3Last;
    logic [2:0]            s3Ready;
    logic                  w3Req;
    logic [FDW3-1:0]       w3Data;
    logic                  full3;
    logic                  grant3Valid;
    logic [1:0]            grant3Id;
    logic [FDW3-1:0]       exp3;

    exp_t  expQ[$];
    beat_t srcQ[N][$];
    logic  accepted[N];
    logic  fullPending;
    int    testsRun, testsFailed;
    int    cycle, writesSeen, firstWrite, lastWrite;

    fifo_rr_write_arbiter #(.N_SRC(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk(clk), .nrst(nrst), .s_valid_i(sValid), .s_data_i(sData), .s_last_i(sLast),
        .s_ready_o(sReady), .fifo_w_req_o(wReq), .fifo_w_data_o(wData),
        .fifo_full_i(fifoFull), .grant_valid_o(grantValid), .grant_id_o(grantId)
    );

    fifo_rr_write_arbiter #(.N_SRC(3), .DATA_W(DW), .BURST_MAX(BM)) dut3 (
        .clk(clk), .nrst(nrst), .s_valid_i(s3Valid), .s_data_i(s3Data), .s_last_i(s3Last),
        .s_ready_o(s3Ready), .fifo_w_req_o(w3Req), .fifo_w_data_o(w3Data),
        .fifo_full_i(full3), .grant_valid_o(grant3Valid), .grant_id_o(grant3Id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [FDW-1:0] expData(input exp_t e);
`ifdef FIFO_ARB_TAG_EN
        return {SW'(e.src), e.data};
`else
        return e.data;
`endif
    endfunction

    task automatic loadSrc(input int src, input int n, input logic [DW-1:0] base, input bit withLast);
        for (int k = 0; k < n; k++) begin
            beat_t b;
            b.data = base + DW'(k);
            b.last = withLast && (k == n - 1);
            srcQ[src].push_back(b);
        end
    endtask

    task automatic pushExp(input int src, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.src  = src;
            e.data = base + DW'(k);
            expQ.push_back(e);
        end
    endtask

    // One cycle: retire last cycle's handshakes, drive producers, then sample outputs.
    task automatic applyStimulus();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (accepted[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
        end
        fifoFull = fullPending;
        for (int i = 0; i < N; i++) begin
            if (srcQ[i].size() > 0) begin
                sValid[i] = 1'b1;
                sData[i]  = srcQ[i][0].data;
                sLast[i]  = srcQ[i][0].last;
            end else begin
                sValid[i] = 1'b0;
                sData[i]  = '0;
                sLast[i]  = 1'b0;
            end
        end
        #1;
        cycle++;
        if (wReq) begin
            writesSeen++;
            if (firstWrite < 0) firstWrite = cycle;
            lastWrite = cycle;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_write", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("w_data", 64'(wData), 64'(expData(e)));
                checkOutput("w_src", 64'(grantId), 64'(e.src));
                checkOutput("w_while_full", 64'(fifoFull), 64'd0);
            end
        end
        for (int i = 0; i < N; i++) accepted[i] = sValid[i] & sReady[i];
    endtask

    function automatic bit drained();
        bit busy;
        busy = (expQ.size() > 0);
        for (int i = 0; i < N; i++) busy = busy | (srcQ[i].size() > 0) | accepted[i];
        return !busy;
    endfunction

    task automatic runUntilDrained(input int maxCycles, input string tag);
        int k;
        k = 0;
        while (!drained() && k < maxCycles) begin
            applyStimulus();
            k++;
        end
        checkOutput({tag, "_drained"}, 64'(drained()), 64'd1);
    endtask

    task automatic resetWindow();
        firstWrite = -1;
        lastWrite  = -1;
        writesSeen = 0;
    endtask

    initial begin
        testsRun = 0; testsFailed = 0; cycle = 0;
        nrst = 1'b0; sValid = '0; sData = '0; sLast = '0; fifoFull = 1'b0; fullPending = 1'b0;
        s3Valid = '0; s3Data = '0; s3Last = '0; full3 = 1'b0; exp3 = '0;
        for (int i = 0; i < N; i++) accepted[i] = 1'b0;
        resetWindow();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_grant_valid", 64'(grantValid), 64'd0);
        checkOutput("rst_grant_id", 64'(grantId), 64'd0);
        checkOutput("rst_w_req", 64'(wReq), 64'd0);
        checkOutput("rst_w_data", 64'(wData), 64'd0);
        checkOutput("rst_s_ready", 64'(sReady), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        $display("[TB] single producer, source 2, three beats");
        resetWindow();
        loadSrc(2, 3, 32'hA0, 1'b1);
        pushExp(2, 3, 32'hA0);
        applyStimulus();
        checkOutput("t1_idle_pick", 64'(grantValid), 64'd0);
        applyStimulus();
        checkOutput("t1_grant_valid", 64'(grantValid), 64'd1);
        checkOutput("t1_grant_id", 64'(grantId), 64'd2);
        checkOutput("t1_first_write", 64'(wReq), 64'd1);
        runUntilDrained(20, "t1");
        checkOutput("t1_beats", 64'(writesSeen), 64'd3);
        checkOutput("t1_back_to_back", 64'(lastWrite - firstWrite), 64'd2);
        checkOutput("t1_released", 64'(grantValid), 64'd0);

        $display("[TB] pointer after release: source 3 wins over source 0");
        loadSrc(0, 1, 32'hB0, 1'b1);
        loadSrc(3, 1, 32'hB3, 1'b1);
        pushExp(3, 1, 32'hB3);
        pushExp(0, 1, 32'hB0);
        runUntilDrained(20, "t1b");
        loadSrc(3, 1, 32'hC3, 1'b1);
        pushExp(3, 1, 32'hC3);
        runUntilDrained(20, "t1c");

        $display("[TB] all sources requesting, no last");
        resetWindow();
        loadSrc(0, 8, 32'h00, 1'b0);
        loadSrc(1, 4, 32'h10, 1'b0);
        loadSrc(2, 4, 32'h20, 1'b0);
        loadSrc(3, 4, 32'h30, 1'b0);
        pushExp(0, 4, 32'h00);
        pushExp(1, 4, 32'h10);
        pushExp(2, 4, 32'h20);
        pushExp(3, 4, 32'h30);
        pushExp(0, 4, 32'h04);
        runUntilDrained(80, "t2");
        checkOutput("t2_beats", 64'(writesSeen), 64'd20);
        checkOutput("t2_bubbles", 64'(lastWrite - firstWrite), 64'd23);

        $display("[TB] FIFO full stall during burst");
        loadSrc(1, 4, 32'h50, 1'b0);
        loadSrc(2, 1, 32'h5F, 1'b1);
        pushExp(1, 4, 32'h50);
        pushExp(2, 1, 32'h5F);
        applyStimulus();
        applyStimulus();
        checkOutput("t3_beat1", 64'(wReq), 64'd1);
        fullPending = 1'b1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus();
            checkOutput("t3_ready_stall", 64'(sReady), 64'd0);
            checkOutput("t3_wreq_stall", 64'(wReq), 64'd0);
            checkOutput("t3_grant_held", 64'(grantValid), 64'd1);
            checkOutput("t3_grant_id", 64'(grantId), 64'd1);
        end
        fullPending = 1'b0;
        runUntilDrained(30, "t3");

        $display("[TB] three-source wrap");
        @(negedge clk);
        s3Valid = 3'b100; s3Last = 3'b100; s3Data[2] = 32'h22;
        #1;
        checkOutput("t4_idle", 64'(grant3Valid), 64'd0);
        @(negedge clk);
        #1;
`ifdef FIFO_ARB_TAG_EN
        exp3 = {2'd2, 32'h22};
`else
        exp3 = 32'h22;
`endif
        checkOutput("t4_grant2_id", 64'(grant3Id), 64'd2);
        checkOutput("t4_grant2_wreq", 64'(w3Req), 64'd1);
        checkOutput("t4_grant2_data", 64'(w3Data), 64'(exp3));
        @(negedge clk);
        s3Valid = 3'b001; s3Last = 3'b001; s3Data[0] = 32'h33; s3Data[2] = '0;
        #1;
        checkOutput("t4_rel_valid", 64'(grant3Valid), 64'd0);
        checkOutput("t4_rel_id_hold", 64'(grant3Id), 64'd2);
        @(negedge clk);
        #1;
`ifdef FIFO_ARB_TAG_EN
        exp3 = {2'd0, 32'h33};
`else
        exp3 = 32'h33;
`endif
        checkOutput("t4_wrap_id", 64'(grant3Id), 64'd0);
        checkOutput("t4_wrap_wreq", 64'(w3Req), 64'd1);
        checkOutput("t4_wrap_data", 64'(w3Data), 64'(exp3));
        @(negedge clk);
        s3Valid = '0; s3Last = '0; s3Data = '0;

        $display("[TB] reset mid-burst");
        resetWindow();
        loadSrc(1, 4, 32'h60, 1'b0);
        pushExp(1, 2, 32'h60);
        begin
            int k;
            k = 0;
            while (writesSeen < 2 && k < 20) begin
                applyStimulus();
                k++;
            end
        end
        checkOutput("t5_two_beats", 64'(writesSeen), 64'd2);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        checkOutput("t5_no_write_in_reset", 64'(wReq), 64'd0);
        checkOutput("t5_no_ready_in_reset", 64'(sReady), 64'd0);
        @(negedge clk);
        #1;
        checkOutput("t5_grant_valid", 64'(grantValid), 64'd0);
        checkOutput("t5_grant_id", 64'(grantId), 64'd0);
        checkOutput("t5_w_req", 64'(wReq), 64'd0);
        for (int i = 0; i < N; i++) begin
            srcQ[i].delete();
            accepted[i] = 1'b0;
        end
        sValid = '0; sLast = '0; sData = '0;
        nrst = 1'b1;
        loadSrc(1, 1, 32'h71, 1'b1);
        loadSrc(3, 1, 32'h73, 1'b1);
        pushExp(1, 1, 32'h71);
        pushExp(3, 1, 32'h73);
        runUntilDrained(20, "t5");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
